keyb_scanner: RTL and testbench

//  4x4 matrix-keypad scanner, directly upstream of the keypad-to-BCD decoder.

---
 rtl/keyb_scanner.sv | 180 ++++++++++++++++++
 tb/tb_keyb_scanner.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keyb_scanner.sv
// 4x4 matrix-keypad scanner: row strobing, column synchronisation, press/release debounce.
// Define KEYB_AUTOREPEAT_EN to add periodic KEY_VALID repeats while a key stays held.
module keyb_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8,
    parameter int REPEAT_TICKS = 200
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [3:0] COL,
    output logic [3:0] ROW,
    output logic       D0,
    output logic       D1,
    output logic       Q0,
    output logic       Q1,
    output logic       KEY_VALID,
    output logic       KEY_HELD,
    output logic [1:0] dbg_state
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t          state, state_n;
    logic [3:0]      cs_meta, cs;
    logic [SW-1:0]   slot;
    logic [1:0]      r, r_n, c, c_n, low_c;
    logic [CW-1:0]   cnt, cnt_n, cnt_inc;
    logic [3:0]      code, code_n;
    logic            valid, valid_n, held, held_n;
    logic            tick, cnt_done;

`ifdef KEYB_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    logic [RW-1:0]   rep, rep_n;
`else
    logic            unused_repeat;
    assign unused_repeat = ^REPEAT_TICKS;
`endif

    assign tick     = (slot == SW'(SCAN_DIV - 1));
    assign cnt_inc  = (cnt == CW'(DEBOUNCE_CNT)) ? cnt : cnt + CW'(1);
    assign cnt_done = (cnt_inc == CW'(DEBOUNCE_CNT));

    // Lowest-index low column wins when several are pressed in the same row.
    always_comb begin
        if (!cs[0])      low_c = 2'd0;
        else if (!cs[1]) low_c = 2'd1;
        else if (!cs[2]) low_c = 2'd2;
        else             low_c = 2'd3;
    end

    always_comb begin
        state_n = state;
        r_n     = r;
        c_n     = c;
        cnt_n   = cnt;
        code_n  = code;
        valid_n = 1'b0;
        held_n  = held;
`ifdef KEYB_AUTOREPEAT_EN
        rep_n   = rep;
`endif
        if (tick) begin
            case (state)
                SCAN: begin
                    if (cs == 4'hF) begin
                        r_n = r + 2'd1;
                    end else begin
                        c_n   = low_c;
                        cnt_n = CW'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            state_n = PRESSED;
                            code_n  = {r, low_c};
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                        end else begin
                            state_n = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!cs[c]) begin
                        cnt_n = cnt_inc;
                        if (cnt_done) begin
                            state_n = PRESSED;
                            code_n  = {r, c};
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                        end
                    end else begin
                        state_n = SCAN;
                        r_n     = r + 2'd1;
                    end
                end
                PRESSED: begin
                    if (cs[c]) begin
                        cnt_n = CW'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            state_n = SCAN;
                            held_n  = 1'b0;
                            r_n     = r + 2'd1;
`ifdef KEYB_AUTOREPEAT_EN
                            rep_n   = '0;
`endif
                        end else begin
                            state_n = RELEASE;
                        end
`ifdef KEYB_AUTOREPEAT_EN
                    end else if (rep + RW'(1) >= RW'(REPEAT_TICKS)) begin
                        valid_n = 1'b1;
                        rep_n   = '0;
                    end else begin
                        rep_n   = rep + RW'(1);
`endif
                    end
                end
                RELEASE: begin
                    // Repeat count is only frozen here so a release bounce does not restart it.
                    if (cs[c]) begin
                        cnt_n = cnt_inc;
                        if (cnt_done) begin
                            state_n = SCAN;
                            held_n  = 1'b0;
                            r_n     = r + 2'd1;
`ifdef KEYB_AUTOREPEAT_EN
                            rep_n   = '0;
`endif
                        end
                    end else begin
                        state_n = PRESSED;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cs_meta <= 4'hF;
            cs      <= 4'hF;
            slot    <= '0;
            state   <= SCAN;
            r       <= 2'd0;
            c       <= 2'd0;
            cnt     <= '0;
            code    <= 4'd0;
            valid   <= 1'b0;
            held    <= 1'b0;
        end else begin
            cs_meta <= COL;
            cs      <= cs_meta;
            slot    <= tick ? '0 : slot + SW'(1);
            state   <= state_n;
            r       <= r_n;
            c       <= c_n;
            cnt     <= cnt_n;
            code    <= code_n;
            valid   <= valid_n;
            held    <= held_n;
        end
    end

`ifdef KEYB_AUTOREPEAT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) rep <= '0;
        else       rep <= rep_n;
    end
`endif

    assign ROW              = ~(4'b0001 << r);
    assign {D0, D1, Q0, Q1} = code;
    assign KEY_VALID        = valid;
    assign KEY_HELD         = held;
    assign dbg_state        = state;

endmodule

// File: tb/tb_keyb_scanner.sv
// Directed bench for keyb_scanner with a combinational keypad model driving COL from ROW.
module tb_keyb_scanner;

    logic        clk = 1'b0;
    logic        nrst;
    logic [3:0]  col;
    logic [3:0]  row;
    logic        d0, d1, q0, q1;
    logic        key_valid, key_held;
    logic [1:0]  dbg_state;
    logic [3:0]  code;
    logic [15:0] keys;
    int          tests = 0;
    int          fails = 0;

`ifdef KEYB_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    keyb_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3), .REPEAT_TICKS(5)) dut (
        .CLK       (clk),
        .nRST      (nrst),
        .COL       (col),
        .ROW       (row),
        .D0        (d0),
        .D1        (d1),
        .Q0        (q0),
        .Q1        (q1),
        .KEY_VALID (key_valid),
        .KEY_HELD  (key_held),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    assign code = {d0, d1, q0, q1};

    // A pressed key at (r,c) pulls column c low only while row r is driven low.
    always_comb begin
        col = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            if (!row[rr])
                for (int cc = 0; cc < 4; cc++)
                    if (keys[rr*4+cc]) col[cc] = 1'b0;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int r, input int c);
        keys[r*4+c] = 1'b1;
    endtask

    // Returns just after the edge on which row first becomes target.
    task automatic align_row(input logic [3:0] target);
        logic [3:0] prev;
        int n;
        prev = row;
        for (n = 0; n < 64; n++) begin
            step(1);
            if (row == target && prev != target) break;
            prev = row;
        end
        tests++;
        if (n == 64) begin
            fails++;
            $display("FAIL align_row: row never became %b (now %b)", target, row);
        end
    endtask

    task automatic wait_held_low();
        int n;
        for (n = 0; n < 64; n++) begin
            step(1);
            if (key_held == 1'b0) break;
        end
        tests++;
        if (n == 64) begin
            fails++;
            $display("FAIL wait_held_low: KEY_HELD still %b after 64 cycles", key_held);
        end
    endtask

    task automatic test_reset();
        logic [3:0] one;
        logic [3:0] exp_row;
        one  = 4'b0001;
        nrst = 1'b0;
        keys = '0;
        step(3);
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL reset_held: got %b want 0", key_held); end
        tests++; if (code !== 4'b0000) begin fails++; $display("FAIL reset_code: got %b want 0000", code); end
        tests++; if (row !== 4'b1110) begin fails++; $display("FAIL reset_row: got %b want 1110", row); end
        tests++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        nrst = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            exp_row = ~(one << ((i / 4) % 4));
            tests++;
            if (row !== exp_row) begin
                fails++;
                $display("FAIL scan_row cycle %0d: got %b want %b", i, row, exp_row);
            end
        end
    endtask

    task automatic test_press();
        press(2, 1);
        align_row(4'b1011);
        for (int i = 1; i <= 11; i++) begin
            step(1);
            tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL press_early_valid cycle %0d: got %b want 0", i, key_valid); end
        end
        step(1);
        tests++; if (key_valid !== 1'b1) begin fails++; $display("FAIL press_valid: got %b want 1", key_valid); end
        tests++; if (code !== 4'b1001) begin fails++; $display("FAIL press_code: got %b want 1001", code); end
        tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL press_held: got %b want 1", key_held); end
        step(1);
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL press_strobe_len: got %b want 0", key_valid); end
        keys = '0;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            tests++; if (key_held !== 1'b1 || key_valid !== 1'b0) begin fails++; $display("FAIL release_hold cycle %0d: held %b valid %b want 1 0", i, key_held, key_valid); end
        end
        step(1);
        tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL release_held: got %b want 0", key_held); end
        tests++; if (row !== 4'b0111) begin fails++; $display("FAIL release_row: got %b want 0111", row); end
    endtask

    task automatic test_glitch();
        press(2, 1);
        align_row(4'b1011);
        step(4);
        keys = '0;
        for (int i = 1; i <= 3; i++) begin
            step(1);
            tests++; if (row !== 4'b1011 || key_valid !== 1'b0) begin fails++; $display("FAIL glitch_hold cycle %0d: row %b valid %b want 1011 0", i, row, key_valid); end
        end
        step(1);
        tests++; if (row !== 4'b0111) begin fails++; $display("FAIL glitch_row: got %b want 0111", row); end
        tests++; if (key_held !== 1'b0 || key_valid !== 1'b0) begin fails++; $display("FAIL glitch_flags: held %b valid %b want 0 0", key_held, key_valid); end
    endtask

    task automatic test_multi();
        logic exp_v;
        press(1, 3);
        press(1, 0);
        align_row(4'b1101);
        step(12);
        tests++; if (key_valid !== 1'b1) begin fails++; $display("FAIL multi_valid: got %b want 1", key_valid); end
        tests++; if (code !== 4'b0100) begin fails++; $display("FAIL multi_code: got %b want 0100", code); end
        press(3, 2);
        for (int i = 1; i <= 40; i++) begin
            step(1);
            exp_v = AUTOREP && (i % 20 == 0);
            tests++;
            if (key_valid !== exp_v || code !== 4'b0100 || row !== 4'b1101 || key_held !== 1'b1) begin
                fails++;
                $display("FAIL multi_ignore cycle %0d: valid %b code %b row %b held %b want %b 0100 1101 1", i, key_valid, code, row, key_held, exp_v);
            end
        end
        keys = '0;
        wait_held_low();
        tests++; if (row !== 4'b1011) begin fails++; $display("FAIL multi_row_after: got %b want 1011", row); end
    endtask

    task automatic test_bounce();
        press(0, 2);
        align_row(4'b1110);
        step(12);
        tests++; if (key_valid !== 1'b1 || code !== 4'b0010) begin fails++; $display("FAIL bounce_accept: valid %b code %b want 1 0010", key_valid, code); end
        keys = '0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            tests++; if (key_held !== 1'b1 || key_valid !== 1'b0) begin fails++; $display("FAIL bounce_rel cycle %0d: held %b valid %b want 1 0", i, key_held, key_valid); end
        end
        press(0, 2);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            tests++; if (key_held !== 1'b1 || key_valid !== 1'b0) begin fails++; $display("FAIL bounce_repress cycle %0d: held %b valid %b want 1 0", i, key_held, key_valid); end
        end
        keys = '0;
        for (int i = 1; i <= 11; i++) begin
            step(1);
            tests++; if (key_held !== 1'b1 || key_valid !== 1'b0) begin fails++; $display("FAIL bounce_final cycle %0d: held %b valid %b want 1 0", i, key_held, key_valid); end
        end
        step(1);
        tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL bounce_held: got %b want 0", key_held); end
        tests++; if (row !== 4'b1101) begin fails++; $display("FAIL bounce_row: got %b want 1101", row); end
        tests++; if (code !== 4'b0010) begin fails++; $display("FAIL bounce_code_kept: got %b want 0010", code); end
    endtask

    task automatic test_reset_mid();
        press(3, 3);
        align_row(4'b0111);
        step(12);
        tests++; if (key_valid !== 1'b1 || code !== 4'b1111) begin fails++; $display("FAIL mid_accept: valid %b code %b want 1 1111", key_valid, code); end
        step(2);
        nrst = 1'b0;
        #1;
        tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL mid_held: got %b want 0", key_held); end
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b want 0", key_valid); end
        tests++; if (code !== 4'b0000) begin fails++; $display("FAIL mid_code: got %b want 0000", code); end
        tests++; if (row !== 4'b1110) begin fails++; $display("FAIL mid_row: got %b want 1110", row); end
        keys = '0;
        step(2);
        nrst = 1'b1;
        step(1);
        tests++; if (row !== 4'b1110 || dbg_state !== 2'd0) begin fails++; $display("FAIL mid_restart: row %b state %0d want 1110 0", row, dbg_state); end
    endtask

`ifdef KEYB_AUTOREPEAT_EN
    task automatic test_autorepeat();
        logic exp_v;
        press(2, 1);
        align_row(4'b1011);
        step(12);
        tests++; if (key_valid !== 1'b1) begin fails++; $display("FAIL rep_first: got %b want 1", key_valid); end
        for (int i = 1; i <= 40; i++) begin
            step(1);
            exp_v = (i % 20 == 0);
            tests++;
            if (key_valid !== exp_v || code !== 4'b1001) begin
                fails++;
                $display("FAIL rep_strobe cycle %0d: valid %b code %b want %b 1001", i, key_valid, code, exp_v);
            end
        end
        keys = '0;
        wait_held_low();
    endtask
`endif

    initial begin
        keys = '0;
        nrst = 1'b0;
        test_reset();
        test_press();
        test_glitch();
        test_multi();
        test_bounce();
        test_reset_mid();
`ifdef KEYB_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
